// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the wb_master_arb Wishbone master arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_XFER    = 2'd1,
    ST_BACKOFF = 2'd2,
    ST_ERR     = 2'd3
  } state_e;

  localparam int RCNT_W = 8;
  localparam int GAP_W  = 4;

  function automatic logic [2:0] onehot2bin(input logic [7:0] oh);
    logic [2:0] b;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) b = b | 3'(i);
    end
    return b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: one-hot grant to the first request at or
// after ptr_i, wrapping past channel NCH-1.
module rr_arbiter #(
  parameter int NCH = 4,
  parameter int PW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req_i,
  input  logic [PW-1:0]  ptr_i,
  output logic [NCH-1:0] gnt_o
);

  always_comb begin
    int          idx_int;
    logic [PW-1:0] idx;
    logic        found;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    gnt_o   = '0;
    found   = 1'b0;
    idx_int = 0;
    idx     = '0;
    for (int i = 0; i < NCH; i++) begin
      idx_int = int'(ptr_i) + i;
      if (idx_int >= NCH) idx_int = idx_int - NCH;
      idx = PW'(idx_int);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_master_arb.sv
// N-channel Wishbone master arbiter with burst lock, retry absorption and
// retry-exhaustion error. Optional bus watchdog: define WB_ARB_TIMEOUT_EN.
module wb_master_arb
  import wb_arb_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int DW        = 64,
  parameter int AW        = 32,
  parameter int MAX_RETRY = 15,
  parameter int RTY_GAP   = 4,
  parameter int TIMEOUT   = 255,
  parameter int SW        = DW / 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rstn_i,
  input  logic [NCH-1:0]    ch_cyc_i,
  input  logic [NCH-1:0]    ch_stb_i,
  input  logic [NCH-1:0]    ch_we_i,
  input  logic [NCH-1:0]    ch_cab_i,
  input  logic [NCH*AW-1:0] ch_adr_i,
  input  logic [NCH*SW-1:0] ch_sel_i,
  input  logic [NCH*DW-1:0] ch_dat_i,
  output logic [DW-1:0]     ch_dat_o,
  output logic [NCH-1:0]    ch_ack_o,
  output logic [NCH-1:0]    ch_err_o,
  output logic [NCH-1:0]    ch_gnt_o,
  output logic              m_cyc_o,
  output logic              m_stb_o,
  output logic              m_we_o,
  output logic              m_cab_o,
  output logic [AW-1:0]     m_adr_o,
  output logic [SW-1:0]     m_sel_o,
  output logic [DW-1:0]     m_dat_o,
  input  logic [DW-1:0]     m_dat_i,
  input  logic              m_ack_i,
  input  logic              m_err_i,
  input  logic              m_rty_i,
  output logic [7:0]        rty_cnt_o
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  state_e              state_q, state_d;
  logic [NCH-1:0]      gnt_q, gnt_d, arb_gnt;
  logic [PW-1:0]       ptr_q, ptr_d, g, ptr_rot;
  logic [RCNT_W-1:0]   rcnt_q, rcnt_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [7:0]          rty_cnt_q, rty_cnt_d;
  logic [7:0]          gnt8;
  logic                xfer;
`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0]         wdog_q, wdog_d;
`endif

  rr_arbiter #(.NCH(NCH), .PW(PW)) u_rr_arbiter (
    .req_i (ch_cyc_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt)
  );

  always_comb begin
    gnt8           = '0;
    gnt8[NCH-1:0]  = gnt_q;
    g              = PW'(onehot2bin(gnt8));
    ptr_rot        = (int'(g) == NCH - 1) ? '0 : g + PW'(1);
  end

  assign xfer      = (state_q == ST_XFER);
  assign ch_gnt_o  = gnt_q;
  assign rty_cnt_o = rty_cnt_q;

  // The bus side is a pure mux of the owner, and only while a beat may be live.
  always_comb begin
    m_cyc_o  = 1'b0;
    m_stb_o  = 1'b0;
    m_we_o   = 1'b0;
    m_cab_o  = 1'b0;
    m_adr_o  = '0;
    m_sel_o  = '0;
    m_dat_o  = '0;
    ch_dat_o = '0;
    ch_ack_o = '0;
    ch_err_o = '0;
    if (xfer) begin
      m_cyc_o     = ch_cyc_i[g];
      m_stb_o     = ch_stb_i[g];
      m_we_o      = ch_we_i[g];
      m_cab_o     = ch_cab_i[g];
      m_adr_o     = ch_adr_i[g*AW +: AW];
      m_sel_o     = ch_sel_i[g*SW +: SW];
      m_dat_o     = ch_dat_i[g*DW +: DW];
      ch_dat_o    = m_dat_i;
      ch_ack_o[g] = m_ack_i;
      ch_err_o[g] = m_err_i;
    end else if (state_q == ST_ERR) begin
      ch_err_o[g] = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    rcnt_d    = rcnt_q;
    gap_d     = gap_q;
    rty_cnt_d = rty_cnt_q;
`ifdef WB_ARB_TIMEOUT_EN
    wdog_d    = wdog_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
`ifdef WB_ARB_TIMEOUT_EN
        wdog_d = '0;
`endif
        if (|ch_cyc_i) begin
          gnt_d   = arb_gnt;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (!ch_cyc_i[g]) begin
          gnt_d   = '0;
          ptr_d   = ptr_rot;
          rcnt_d  = '0;
          state_d = ST_IDLE;
        end else if (m_ack_i || m_err_i) begin
          // Ack beats a simultaneous rty; the beat is complete.
          rcnt_d = '0;
`ifdef WB_ARB_TIMEOUT_EN
          wdog_d = '0;
`endif
        end else if (m_rty_i) begin
`ifdef WB_ARB_TIMEOUT_EN
          wdog_d = '0;
`endif
          if (rcnt_q < RCNT_W'(MAX_RETRY)) begin
            rcnt_d    = rcnt_q + 1'b1;
            rty_cnt_d = (rty_cnt_q == 8'hFF) ? rty_cnt_q : rty_cnt_q + 1'b1;
            gap_d     = GAP_W'(RTY_GAP - 1);
            state_d   = ST_BACKOFF;
          end else begin
            state_d = ST_ERR;
          end
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (m_stb_o) begin
          if (wdog_q == 16'(TIMEOUT - 1)) begin
            wdog_d  = '0;
            state_d = ST_ERR;
          end else begin
            wdog_d = wdog_q + 1'b1;
          end
        end
`endif
      end
      ST_BACKOFF: begin
        if (!ch_cyc_i[g]) begin
          gnt_d   = '0;
          ptr_d   = ptr_rot;
          rcnt_d  = '0;
          state_d = ST_IDLE;
        end else if (gap_q == '0) begin
          state_d = ST_XFER;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      ST_ERR: begin
        rcnt_d  = '0;
        state_d = ST_XFER;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: reset is synchronous here, so it lives inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rstn_i) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      ptr_q     <= '0;
      rcnt_q    <= '0;
      gap_q     <= '0;
      rty_cnt_q <= '0;
`ifdef WB_ARB_TIMEOUT_EN
      wdog_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      rcnt_q    <= rcnt_d;
      gap_q     <= gap_d;
      rty_cnt_q <= rty_cnt_d;
`ifdef WB_ARB_TIMEOUT_EN
      wdog_q    <= wdog_d;
`endif
    end
  end

endmodule

// File: tb/tb_wb_master_arb.sv
// Directed bench for wb_master_arb: table-driven arbitration/burst vectors plus
// hand-written retry, retry-exhaustion, timeout and reset sequences.
module tb_wb_master_arb;

  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int SW  = DW / 8;

  logic              clk = 1'b0;
  logic              rstn;
  logic [NCH-1:0]    ch_cyc, ch_stb, ch_we, ch_cab;
  logic [NCH*AW-1:0] ch_adr;
  logic [NCH*SW-1:0] ch_sel;
  logic [NCH*DW-1:0] ch_dat;
  logic [DW-1:0]     ch_dat_o;
  logic [NCH-1:0]    ch_ack_o, ch_err_o, ch_gnt_o;
  logic              m_cyc_o, m_stb_o, m_we_o, m_cab_o;
  logic [AW-1:0]     m_adr_o;
  logic [SW-1:0]     m_sel_o;
  logic [DW-1:0]     m_dat_o, m_dat_i;
  logic              m_ack, m_err, m_rty;
  logic [7:0]        rty_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_master_arb #(
    .NCH(NCH), .DW(DW), .AW(AW), .MAX_RETRY(3), .RTY_GAP(4), .TIMEOUT(16)
  ) dut (
    .wb_clk_i (clk),      .wb_rstn_i (rstn),
    .ch_cyc_i (ch_cyc),   .ch_stb_i  (ch_stb),   .ch_we_i (ch_we), .ch_cab_i (ch_cab),
    .ch_adr_i (ch_adr),   .ch_sel_i  (ch_sel),   .ch_dat_i (ch_dat),
    .ch_dat_o (ch_dat_o), .ch_ack_o  (ch_ack_o), .ch_err_o (ch_err_o), .ch_gnt_o (ch_gnt_o),
    .m_cyc_o  (m_cyc_o),  .m_stb_o   (m_stb_o),  .m_we_o  (m_we_o),  .m_cab_o  (m_cab_o),
    .m_adr_o  (m_adr_o),  .m_sel_o   (m_sel_o),  .m_dat_o (m_dat_o), .m_dat_i  (m_dat_i),
    .m_ack_i  (m_ack),    .m_err_i   (m_err),    .m_rty_i (m_rty),
    .rty_cnt_o(rty_cnt_o)
  );

  typedef struct {
    logic [3:0] cyc, stb;
    logic       ack, rty, err;
    logic [3:0] gnt, ack_o, err_o;
    logic       mcyc, mstb;
  } vec_t;

  vec_t tv[$];

  function automatic logic [AW-1:0] adr_of(input int k);
    return 32'h1000_0000 + 32'(k) * 32'h100;
  endfunction

  function automatic logic [DW-1:0] dat_of(input int k);
    return 32'hD000_0000 + 32'(k);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One bus cycle: drive just after the rising edge, return at the falling edge for sampling.
  task automatic step(input logic [3:0] cyc, input logic [3:0] stb,
                      input logic ack, input logic rty, input logic err);
    @(posedge clk);
    #1;
    ch_cyc = cyc;
    ch_stb = stb;
    m_ack  = ack;
    m_rty  = rty;
    m_err  = err;
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    check({tag, " m_cyc"},   64'(m_cyc_o),   64'd0);
    check({tag, " m_stb"},   64'(m_stb_o),   64'd0);
    check({tag, " m_we"},    64'(m_we_o),    64'd0);
    check({tag, " m_cab"},   64'(m_cab_o),   64'd0);
    check({tag, " m_adr"},   64'(m_adr_o),   64'd0);
    check({tag, " m_sel"},   64'(m_sel_o),   64'd0);
    check({tag, " m_dat"},   64'(m_dat_o),   64'd0);
    check({tag, " ch_dat"},  64'(ch_dat_o),  64'd0);
    check({tag, " gnt"},     64'(ch_gnt_o),  64'd0);
    check({tag, " ack"},     64'(ch_ack_o),  64'd0);
    check({tag, " err"},     64'(ch_err_o),  64'd0);
    check({tag, " rty_cnt"}, 64'(rty_cnt_o), 64'd0);
  endtask

  task automatic add(input logic [3:0] cyc, input logic [3:0] stb, input logic ack,
                     input logic rty, input logic err, input logic [3:0] gnt,
                     input logic [3:0] ack_o, input logic [3:0] err_o,
                     input logic mcyc, input logic mstb);
    vec_t v;
    v.cyc = cyc; v.stb = stb; v.ack = ack; v.rty = rty; v.err = err;
    v.gnt = gnt; v.ack_o = ack_o; v.err_o = err_o; v.mcyc = mcyc; v.mstb = mstb;
    tv.push_back(v);
  endtask

  initial begin
    rstn    = 1'b0;
    ch_cyc  = '0; ch_stb = '0;
    ch_we   = 4'b1010;
    ch_cab  = 4'b0010;
    m_ack   = 1'b0; m_rty = 1'b0; m_err = 1'b0;
    m_dat_i = 32'hCAFE_F00D;
    for (int k = 0; k < NCH; k++) begin
      ch_adr[k*AW +: AW] = adr_of(k);
      ch_dat[k*DW +: DW] = dat_of(k);
      ch_sel[k*SW +: SW] = 4'b0001 << k;
    end

    // Arbitration and burst vectors (cyc, stb, ack, rty, err | gnt, ack_o, err_o, m_cyc, m_stb).
    add(4'b0101, 4'b0101, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add(4'b0101, 4'b0101, 0, 0, 0, 4'b0001, 4'b0000, 4'b0000, 1, 1);
    add(4'b0100, 4'b0100, 0, 0, 0, 4'b0001, 4'b0000, 4'b0000, 0, 0);
    add(4'b0100, 4'b0100, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add(4'b0100, 4'b0100, 0, 0, 0, 4'b0100, 4'b0000, 4'b0000, 1, 1);
    add(4'b0100, 4'b0100, 1, 0, 0, 4'b0100, 4'b0100, 4'b0000, 1, 1);
    add(4'b0000, 4'b0000, 0, 0, 0, 4'b0100, 4'b0000, 4'b0000, 0, 0);
    add(4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add(4'b0010, 4'b0010, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add(4'b1010, 4'b1010, 1, 1, 0, 4'b0010, 4'b0010, 4'b0000, 1, 1);
    for (int i = 0; i < 7; i++)
      add(4'b1010, 4'b1010, 1, 0, 0, 4'b0010, 4'b0010, 4'b0000, 1, 1);
    add(4'b1000, 4'b1000, 0, 0, 0, 4'b0010, 4'b0000, 4'b0000, 0, 0);
    add(4'b1000, 4'b1000, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add(4'b1000, 4'b1000, 0, 0, 1, 4'b1000, 4'b0000, 4'b1000, 1, 1);
    add(4'b0000, 4'b0000, 0, 0, 0, 4'b1000, 4'b0000, 4'b0000, 0, 0);
    add(4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0);

    // Reset state.
    for (int i = 0; i < 3; i++) step('0, '0, 0, 0, 0);
    chk_zero("reset");
    rstn = 1'b1;

    foreach (tv[i]) begin
      step(tv[i].cyc, tv[i].stb, tv[i].ack, tv[i].rty, tv[i].err);
      check($sformatf("v%0d gnt", i),   64'(ch_gnt_o), 64'(tv[i].gnt));
      check($sformatf("v%0d ack", i),   64'(ch_ack_o), 64'(tv[i].ack_o));
      check($sformatf("v%0d err", i),   64'(ch_err_o), 64'(tv[i].err_o));
      check($sformatf("v%0d m_cyc", i), 64'(m_cyc_o),  64'(tv[i].mcyc));
      check($sformatf("v%0d m_stb", i), 64'(m_stb_o),  64'(tv[i].mstb));
    end

    // Two rty then ack on ch2: 4 idle cycles after each rty, same beat replayed.
    step(4'b0100, 4'b0100, 0, 0, 0);
    for (int r = 0; r < 2; r++) begin
      step(4'b0100, 4'b0100, 0, 1, 0);
      check($sformatf("rty%0d m_cyc", r), 64'(m_cyc_o),  64'd1);
      check($sformatf("rty%0d m_adr", r), 64'(m_adr_o),  64'(adr_of(2)));
      check($sformatf("rty%0d m_sel", r), 64'(m_sel_o),  64'h4);
      check($sformatf("rty%0d m_dat", r), 64'(m_dat_o),  64'(dat_of(2)));
      check($sformatf("rty%0d ack", r),   64'(ch_ack_o), 64'd0);
      for (int b = 0; b < 4; b++) begin
        step(4'b0100, 4'b0100, 0, 0, 0);
        check($sformatf("rty%0d gap%0d m_cyc", r, b), 64'(m_cyc_o),  64'd0);
        check($sformatf("rty%0d gap%0d gnt", r, b),   64'(ch_gnt_o), 64'h4);
        check($sformatf("rty%0d gap%0d err", r, b),   64'(ch_err_o), 64'd0);
      end
    end
    step(4'b0100, 4'b0100, 1, 0, 0);
    check("replay m_cyc",  64'(m_cyc_o),   64'd1);
    check("replay m_adr",  64'(m_adr_o),   64'(adr_of(2)));
    check("replay ack",    64'(ch_ack_o),  64'h4);
    check("replay err",    64'(ch_err_o),  64'd0);
    check("replay ch_dat", 64'(ch_dat_o),  64'hCAFE_F00D);
    check("replay rty_cnt", 64'(rty_cnt_o), 64'd2);
    step('0, '0, 0, 0, 0);
    step('0, '0, 0, 0, 0);

    // Retry exhaustion on ch1 with MAX_RETRY=3; counter cleared by reset first.
    rstn = 1'b0;
    step('0, '0, 0, 0, 0);
    step('0, '0, 0, 0, 0);
    chk_zero("rst2");
    rstn = 1'b1;
    step(4'b0010, 4'b0010, 0, 0, 0);
    for (int r = 0; r < 4; r++) begin
      step(4'b0010, 4'b0010, 0, 1, 0);
      check($sformatf("exh%0d m_cyc", r), 64'(m_cyc_o),  64'd1);
      check($sformatf("exh%0d m_we", r),  64'(m_we_o),   64'd1);
      check($sformatf("exh%0d m_cab", r), 64'(m_cab_o),  64'd1);
      check($sformatf("exh%0d err", r),   64'(ch_err_o), 64'd0);
      if (r < 3) begin
        for (int b = 0; b < 4; b++) begin
          step(4'b0010, 4'b0010, 0, 1, 0);
          check($sformatf("exh%0d gap%0d m_cyc", r, b), 64'(m_cyc_o), 64'd0);
        end
      end
    end
    step(4'b0010, 4'b0010, 0, 1, 0);
    check("exh err pulse", 64'(ch_err_o), 64'h2);
    check("exh err m_cyc", 64'(m_cyc_o),  64'd0);
    check("exh err ack",   64'(ch_ack_o), 64'd0);
    step(4'b0010, 4'b0010, 0, 0, 0);
    check("exh err single", 64'(ch_err_o),  64'd0);
    check("exh resume cyc", 64'(m_cyc_o),   64'd1);
    check("exh rty_cnt",    64'(rty_cnt_o), 64'd3);
    step('0, '0, 0, 0, 0);
    step('0, '0, 0, 0, 0);

    // Silent bridge on ch0 (ptr=2 wraps to ch0).
    step(4'b0001, 4'b0001, 0, 0, 0);
`ifdef WB_ARB_TIMEOUT_EN
    for (int k = 0; k <= 16; k++) begin
      step(4'b0001, 4'b0001, 0, 0, 0);
      if (k < 16) begin
        check($sformatf("tmo c%0d err", k),   64'(ch_err_o), 64'd0);
        check($sformatf("tmo c%0d m_stb", k), 64'(m_stb_o),  64'd1);
      end else begin
        check("tmo err pulse", 64'(ch_err_o), 64'h1);
        check("tmo err m_cyc", 64'(m_cyc_o),  64'd0);
      end
    end
`else
    for (int k = 0; k < 40; k++) begin
      step(4'b0001, 4'b0001, 0, 0, 0);
      check($sformatf("wait c%0d m_stb", k), 64'(m_stb_o),  64'd1);
      check($sformatf("wait c%0d err", k),   64'(ch_err_o), 64'd0);
    end
`endif
    step('0, '0, 0, 0, 0);
    step('0, '0, 0, 0, 0);

    // Reset during BACKOFF (ptr=1 so ch3 wins).
    step(4'b1000, 4'b1000, 0, 0, 0);
    step(4'b1000, 4'b1000, 0, 1, 0);
    check("bo gnt",   64'(ch_gnt_o), 64'h8);
    check("bo m_cyc", 64'(m_cyc_o),  64'd1);
    step(4'b1000, 4'b1000, 0, 0, 0);
    check("bo gap m_cyc", 64'(m_cyc_o), 64'd0);
    rstn = 1'b0;
    step(4'b1000, 4'b1000, 1, 0, 0);
    chk_zero("rst_bo");
    step('0, '0, 0, 0, 0);
    rstn = 1'b1;
    step('0, '0, 0, 0, 0);

    // Reset mid-burst with ptr moved to 3; arbitration must restart from ch0.
    step(4'b0100, 4'b0100, 0, 0, 0);
    step('0, '0, 0, 0, 0);
    step(4'b0010, 4'b0010, 0, 0, 0);
    step(4'b0010, 4'b0010, 1, 0, 0);
    check("burst gnt", 64'(ch_gnt_o), 64'h2);
    check("burst ack", 64'(ch_ack_o), 64'h2);
    rstn = 1'b0;
    step(4'b0010, 4'b0010, 1, 0, 0);
    chk_zero("rst_burst");
    step(4'b1001, 4'b1001, 0, 0, 0);
    rstn = 1'b1;
    step(4'b1001, 4'b1001, 0, 0, 0);
    check("post-rst gnt",   64'(ch_gnt_o), 64'h1);
    check("post-rst m_adr", 64'(m_adr_o),  64'(adr_of(0)));
    step('0, '0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
